// File: rtl/cfs_algn_pkg.sv
// -----------------------------------------------------------------------------
// cfs_algn_pkg
// Shared definitions for the Aligner datapath: MD data width, the derived
// offset/size/FIFO-entry widths, the bit positions of the {size, offset, data}
// fields inside a FIFO entry, and a packed struct for that entry. The RX
// controller, this alignment core and the TX controller all use the same
// packing, so the FIFOs between them carry plain vectors of FIFO_DATA_WIDTH.
// -----------------------------------------------------------------------------
package cfs_algn_pkg;

    localparam int ALGN_DATA_WIDTH   = 32;
    localparam int ALGN_BYTES        = ALGN_DATA_WIDTH / 8;
    localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_BYTES);
    localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_BYTES) + 1;
    localparam int FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH;

    // Byte count held in the two-unit accumulator: 0 .. 2*BYTES inclusive.
    localparam int ALGN_CNT_WIDTH    = $clog2(2 * ALGN_BYTES) + 1;

    // Field positions inside a FIFO entry, size in the MSBs.
    localparam int FIFO_DATA_LSB     = 0;
    localparam int FIFO_DATA_MSB     = ALGN_DATA_WIDTH - 1;
    localparam int FIFO_OFFSET_LSB   = ALGN_DATA_WIDTH;
    localparam int FIFO_OFFSET_MSB   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH - 1;
    localparam int FIFO_SIZE_LSB     = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH;
    localparam int FIFO_SIZE_MSB     = FIFO_DATA_WIDTH - 1;

    typedef struct packed {
        logic [ALGN_SIZE_WIDTH-1:0]   size;
        logic [ALGN_OFFSET_WIDTH-1:0] offset;
        logic [ALGN_DATA_WIDTH-1:0]   data;
    } algn_fifo_entry_t;

    // Mask selecting the lowest 'size' bytes of a data word; size==BYTES
    // shifts the all-ones pattern out completely and yields a full mask.
    function automatic logic [ALGN_DATA_WIDTH-1:0] byte_mask(input logic [ALGN_SIZE_WIDTH-1:0] size);
        logic [ALGN_DATA_WIDTH-1:0] ones;
        ones = {ALGN_DATA_WIDTH{1'b1}};
        return ~(ones << {size, 3'b000});
    endfunction

endpackage

// File: rtl/cfs_byte_acc.sv
// -----------------------------------------------------------------------------
// cfs_byte_acc
// Byte accumulator of the alignment core. Holds up to 2*BYTES bytes in arrival
// order (byte 0 = oldest, stored in bits [7:0]) plus the byte count.
// Each cycle it may first drop the oldest shift_size_i bytes (a unit leaving
// to the TX FIFO) and then append app_size_i bytes taken from lane
// app_offset_i of app_data_i at the post-shift fill level.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   shift_i            drop shift_size_i oldest bytes this cycle
//   shift_size_i       number of bytes to drop
//   append_i           append an incoming unit this cycle
//   app_size_i         incoming unit byte count
//   app_offset_i       incoming unit first byte lane
//   app_data_i         incoming unit data word
//   cnt_o              current byte count (registered)
//   cnt_after_o        byte count after this cycle's shift
//   head_o             oldest BYTES bytes of the buffer
// -----------------------------------------------------------------------------
module cfs_byte_acc
    import cfs_algn_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         shift_i,
    input  logic [ALGN_SIZE_WIDTH-1:0]   shift_size_i,
    input  logic                         append_i,
    input  logic [ALGN_SIZE_WIDTH-1:0]   app_size_i,
    input  logic [ALGN_OFFSET_WIDTH-1:0] app_offset_i,
    input  logic [ALGN_DATA_WIDTH-1:0]   app_data_i,
    output logic [ALGN_CNT_WIDTH-1:0]    cnt_o,
    output logic [ALGN_CNT_WIDTH-1:0]    cnt_after_o,
    output logic [ALGN_DATA_WIDTH-1:0]   head_o
);

    localparam int BUF_WIDTH = 2 * ALGN_DATA_WIDTH;

    logic [BUF_WIDTH-1:0]       buf_q;
    logic [BUF_WIDTH-1:0]       buf_d;
    logic [ALGN_CNT_WIDTH-1:0]  cnt_q;
    logic [ALGN_CNT_WIDTH-1:0]  cnt_d;

    logic [ALGN_CNT_WIDTH-1:0]  shift_cnt_s;
    logic [ALGN_CNT_WIDTH-1:0]  cnt_after_s;
    logic [BUF_WIDTH-1:0]       shifted_s;
    logic [ALGN_DATA_WIDTH-1:0] app_field_s;
    logic [BUF_WIDTH-1:0]       app_bytes_s;

    // Shift-then-append: the shift zero-fills the top, and bytes at or above
    // the fill level are always zero, so the append can simply be OR-ed in.
    always_comb begin
        if (shift_i) begin
            shift_cnt_s = ALGN_CNT_WIDTH'(shift_size_i);
        end else begin
            shift_cnt_s = {ALGN_CNT_WIDTH{1'b0}};
        end
        cnt_after_s = cnt_q - shift_cnt_s;
        shifted_s   = buf_q >> {shift_cnt_s, 3'b000};
        app_field_s = (app_data_i >> {app_offset_i, 3'b000}) & byte_mask(app_size_i);
        app_bytes_s = {{ALGN_DATA_WIDTH{1'b0}}, app_field_s} << {cnt_after_s, 3'b000};
        if (append_i) begin
            buf_d = shifted_s | app_bytes_s;
            cnt_d = cnt_after_s + ALGN_CNT_WIDTH'(app_size_i);
        end else begin
            buf_d = shifted_s;
            cnt_d = cnt_after_s;
        end
    end

    // Buffer and count registers; reset discards every accumulated byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= {BUF_WIDTH{1'b0}};
            cnt_q <= {ALGN_CNT_WIDTH{1'b0}};
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign cnt_after_o = cnt_after_s;
    assign head_o      = buf_q[ALGN_DATA_WIDTH-1:0];

endmodule

// File: rtl/cfs_ctrl_align_chk.sv
// -----------------------------------------------------------------------------
// cfs_ctrl_align_chk
// Protocol and integrity checks for the alignment core: legal incoming units,
// accumulator bound, and push-side stability under backpressure.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   pop_fire_i         an RX FIFO entry is consumed this cycle
//   pop_size_i         its size field
//   pop_offset_i       its offset field
//   cnt_i              accumulator byte count
//   push_valid_i       aligned unit offered
//   push_ready_i       TX FIFO accepts
//   push_data_i        offered FIFO entry
// -----------------------------------------------------------------------------
module cfs_ctrl_align_chk
    import cfs_algn_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         pop_fire_i,
    input  logic [ALGN_SIZE_WIDTH-1:0]   pop_size_i,
    input  logic [ALGN_OFFSET_WIDTH-1:0] pop_offset_i,
    input  logic [ALGN_CNT_WIDTH-1:0]    cnt_i,
    input  logic                         push_valid_i,
    input  logic                         push_ready_i,
    input  logic [FIFO_DATA_WIDTH-1:0]   push_data_i
);

    localparam int SUM_WIDTH = ALGN_SIZE_WIDTH + 1;

    a_pop_size_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_fire_i |-> (pop_size_i != {ALGN_SIZE_WIDTH{1'b0}}));

    a_pop_in_lanes: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_fire_i |-> ((SUM_WIDTH'(pop_offset_i) + SUM_WIDTH'(pop_size_i)) <= SUM_WIDTH'(ALGN_BYTES)));

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_i <= ALGN_CNT_WIDTH'(2 * ALGN_BYTES));

    a_push_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_valid_i && !push_ready_i) |=> (push_valid_i && $stable(push_data_i)));

endmodule

// File: rtl/cfs_ctrl_align.sv
// -----------------------------------------------------------------------------
// cfs_ctrl_align
// Alignment core of the Aligner. Pops {size, offset, data} units from the RX
// FIFO, accumulates their valid bytes in order, and pushes units of cfg_size
// bytes placed at byte lane cfg_offset to the TX FIFO. The configuration is
// re-sampled from ctrl_* only while the accumulator is empty and nothing is
// being popped, so a register change lands exactly on a unit boundary.
//
// Ports
//   pclk, preset_n     clock, asynchronous active-low reset
//   ctrl_offset        CTRL.OFFSET from the register block
//   ctrl_size          CTRL.SIZE from the register block (already legal)
//   pop_valid/_ready   RX FIFO handshake, pop_data = {size, offset, data}
//   push_valid/_ready  TX FIFO handshake, push_data = {size, offset, data}
//   busy               accumulator holds at least one byte
// -----------------------------------------------------------------------------
module cfs_ctrl_align
    import cfs_algn_pkg::*;
(
    input  logic                         pclk,
    input  logic                         preset_n,
    input  logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset,
    input  logic [ALGN_SIZE_WIDTH-1:0]   ctrl_size,
    input  logic                         pop_valid,
    input  logic [FIFO_DATA_WIDTH-1:0]   pop_data,
    output logic                         pop_ready,
    output logic                         push_valid,
    output logic [FIFO_DATA_WIDTH-1:0]   push_data,
    input  logic                         push_ready,
    output logic                         busy
);

    logic [ALGN_SIZE_WIDTH-1:0]   cfg_size_q;
    logic [ALGN_SIZE_WIDTH-1:0]   cfg_size_d;
    logic [ALGN_OFFSET_WIDTH-1:0] cfg_offset_q;
    logic [ALGN_OFFSET_WIDTH-1:0] cfg_offset_d;

    algn_fifo_entry_t             pop_entry_s;
    algn_fifo_entry_t             push_entry_s;
    logic [ALGN_CNT_WIDTH-1:0]    cnt_s;
    logic [ALGN_CNT_WIDTH-1:0]    cnt_after_s;
    logic [ALGN_DATA_WIDTH-1:0]   head_s;
    logic                         push_valid_s;
    logic                         push_fire_s;
    logic                         pop_ready_s;
    logic                         pop_fire_s;

    // Handshakes. pop_ready looks at the fill level after this cycle's push,
    // so a full-width unit always fits; this is the only input-to-output path.
    always_comb begin
        pop_entry_s  = pop_data;
        push_valid_s = (cnt_s >= ALGN_CNT_WIDTH'(cfg_size_q));
        push_fire_s  = push_valid_s & push_ready;
        pop_ready_s  = (cnt_after_s <= ALGN_CNT_WIDTH'(ALGN_BYTES));
        pop_fire_s   = pop_valid & pop_ready_s;
    end

    cfs_byte_acc u_acc (
        .clk_i        (pclk),
        .rst_ni       (preset_n),
        .shift_i      (push_fire_s),
        .shift_size_i (cfg_size_q),
        .append_i     (pop_fire_s),
        .app_size_i   (pop_entry_s.size),
        .app_offset_i (pop_entry_s.offset),
        .app_data_i   (pop_entry_s.data),
        .cnt_o        (cnt_s),
        .cnt_after_o  (cnt_after_s),
        .head_o       (head_s)
    );

    // Configuration follows the registers only at an empty, idle boundary.
    always_comb begin
        if ((cnt_s == {ALGN_CNT_WIDTH{1'b0}}) && !pop_fire_s) begin
            cfg_size_d   = ctrl_size;
            cfg_offset_d = ctrl_offset;
        end else begin
            cfg_size_d   = cfg_size_q;
            cfg_offset_d = cfg_offset_q;
        end
    end

    // Configuration registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cfg_size_q   <= {{(ALGN_SIZE_WIDTH-1){1'b0}}, 1'b1};
            cfg_offset_q <= {ALGN_OFFSET_WIDTH{1'b0}};
        end else begin
            cfg_size_q   <= cfg_size_d;
            cfg_offset_q <= cfg_offset_d;
        end
    end

    // Outgoing entry: oldest cfg_size bytes moved up to lane cfg_offset,
    // every other lane zero.
    always_comb begin
        push_entry_s.size   = cfg_size_q;
        push_entry_s.offset = cfg_offset_q;
        push_entry_s.data   = (head_s & byte_mask(cfg_size_q)) << {cfg_offset_q, 3'b000};
    end

    assign pop_ready  = pop_ready_s;
    assign push_valid = push_valid_s;
    assign push_data  = push_entry_s;
    assign busy       = (cnt_s != {ALGN_CNT_WIDTH{1'b0}});

    cfs_ctrl_align_chk u_chk (
        .clk_i        (pclk),
        .rst_ni       (preset_n),
        .pop_fire_i   (pop_fire_s),
        .pop_size_i   (pop_entry_s.size),
        .pop_offset_i (pop_entry_s.offset),
        .cnt_i        (cnt_s),
        .push_valid_i (push_valid_s),
        .push_ready_i (push_ready),
        .push_data_i  (push_entry_s)
    );

endmodule

// File: tb/tb_cfs_ctrl_align.sv
// -----------------------------------------------------------------------------
// tb_cfs_ctrl_align
// Self-checking bench for cfs_ctrl_align with BYTES=4. A byte queue plus the
// current unit size/offset form the reference: outputs are predicted from the
// queue contents each cycle, then the queue is updated with the same
// pop/push decisions the handshake rules imply.
// -----------------------------------------------------------------------------
module tb_cfs_ctrl_align;

    logic        pclk;
    logic        preset_n;
    logic [1:0]  ctrl_offset;
    logic [2:0]  ctrl_size;
    logic        pop_valid;
    logic [36:0] pop_data;
    logic        pop_ready;
    logic        push_valid;
    logic [36:0] push_data;
    logic        push_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state.
    logic [7:0] mq[$];
    int         m_size = 1;
    int         m_off  = 0;
    int         t_ctrl_size = 1;
    int         t_ctrl_off  = 0;

    cfs_ctrl_align dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .ctrl_offset (ctrl_offset),
        .ctrl_size   (ctrl_size),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .pop_ready   (pop_ready),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .busy        (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected TX entry built from the queue: lane m_off+i carries byte i.
    function automatic logic [36:0] exp_push();
        logic [31:0] d;
        logic [2:0]  s;
        logic [1:0]  o;
        int          lane;
        d = 32'h0;
        for (int i = 0; i < m_size; i++) begin
            lane = m_off + i;
            if (lane < 4 && i < mq.size()) d[lane*8 +: 8] = mq[i];
        end
        s = 3'(m_size);
        o = 2'(m_off);
        return {s, o, d};
    endfunction

    task automatic set_ctrl(input int sz, input int off);
        t_ctrl_size = sz;
        t_ctrl_off  = off;
    endtask

    // One clock cycle: drive, predict and compare, then advance the model.
    task automatic step(input logic pv, input int psz, input int poff,
                        input logic [31:0] pdat, input logic prdy);
        int   n;
        int   after;
        logic e_pv;
        logic e_pfire;
        logic e_pr;
        @(negedge pclk);
        ctrl_size   = 3'(t_ctrl_size);
        ctrl_offset = 2'(t_ctrl_off);
        pop_valid   = pv;
        pop_data    = {3'(psz), 2'(poff), pdat};
        push_ready  = prdy;
        #1;
        n       = mq.size();
        e_pv    = (n >= m_size);
        e_pfire = e_pv && prdy;
        after   = n - (e_pfire ? m_size : 0);
        e_pr    = (after <= 4);
        check_eq("push_valid", {63'd0, push_valid}, {63'd0, e_pv});
        check_eq("push_data",  {27'd0, push_data},  {27'd0, exp_push()});
        check_eq("pop_ready",  {63'd0, pop_ready},  {63'd0, e_pr});
        check_eq("busy",       {63'd0, busy},       {63'd0, (n != 0)});
        @(posedge pclk);
        if (e_pfire) begin
            for (int i = 0; i < m_size; i++) void'(mq.pop_front());
        end
        if (pv && e_pr) begin
            for (int i = 0; i < psz; i++) mq.push_back(pdat[(poff+i)*8 +: 8]);
        end else if (n == 0) begin
            m_size = t_ctrl_size;
            m_off  = t_ctrl_off;
        end
    endtask

    task automatic idle(input logic prdy);
        step(1'b0, 0, 0, 32'h0, prdy);
    endtask

    task automatic apply_reset();
        @(negedge pclk);
        pop_valid  = 1'b0;
        push_ready = 1'b0;
        preset_n   = 1'b0;
        #1;
        check_eq("rst_push_valid", {63'd0, push_valid}, 64'd0);
        check_eq("rst_busy",       {63'd0, busy},       64'd0);
        check_eq("rst_pop_ready",  {63'd0, pop_ready},  64'd1);
        check_eq("rst_push_data",  {27'd0, push_data},  {27'd0, 3'd1, 2'd0, 32'h0});
        mq.delete();
        m_size = 1;
        m_off  = 0;
        @(negedge pclk);
        preset_n    = 1'b1;
        ctrl_size   = 3'(t_ctrl_size);
        ctrl_offset = 2'(t_ctrl_off);
        @(posedge pclk);
        m_size = t_ctrl_size;
        m_off  = t_ctrl_off;
    endtask

    initial begin
        int cs[7];
        int co[7];
        int k;
        int psz;
        cs = '{1, 1, 1, 1, 2, 2, 4};
        co = '{0, 1, 2, 3, 0, 2, 0};

        preset_n    = 1'b0;
        ctrl_size   = 3'd1;
        ctrl_offset = 2'd0;
        pop_valid   = 1'b0;
        pop_data    = 37'd0;
        push_ready  = 1'b0;
        apply_reset();

        // Gather two single bytes into one 2-byte unit.
        set_ctrl(2, 0);
        idle(1'b1);
        step(1'b1, 1, 0, 32'h0000_0011, 1'b1);
        step(1'b1, 1, 1, 32'h0000_2200, 1'b1);
        #1 check_eq("gather_data", {27'd0, push_data}, {27'd0, 3'd2, 2'd0, 32'h0000_2211});
        idle(1'b1);
        #1 check_eq("gather_empty", {63'd0, busy}, 64'd0);

        // Merge two halves into one word.
        set_ctrl(4, 0);
        idle(1'b1);
        step(1'b1, 2, 2, 32'hBBAA_0000, 1'b1);
        step(1'b1, 2, 0, 32'h0000_DDCC, 1'b1);
        #1 check_eq("merge_data", {27'd0, push_data}, {27'd0, 3'd4, 2'd0, 32'hDDCC_BBAA});
        idle(1'b1);

        // Split a word into four single-byte units at lane 3.
        set_ctrl(1, 3);
        idle(1'b1);
        step(1'b1, 4, 0, 32'h4433_2211, 1'b1);
        #1 check_eq("split_first", {27'd0, push_data}, {27'd0, 3'd1, 2'd3, 32'h1100_0000});
        for (int i = 0; i < 4; i++) idle(1'b1);
        #1 check_eq("split_empty", {63'd0, busy}, 64'd0);

        // Backpressure: two words fit, the third waits.
        set_ctrl(4, 0);
        idle(1'b1);
        step(1'b1, 4, 0, 32'hA1A2_A3A4, 1'b0);
        step(1'b1, 4, 0, 32'hB1B2_B3B4, 1'b0);
        step(1'b1, 4, 0, 32'hC1C2_C3C4, 1'b0);
        #1 check_eq("bp_pop_blocked", {63'd0, pop_ready}, 64'd0);
        idle(1'b1);
        idle(1'b1);
        #1 check_eq("bp_drained", {63'd0, busy}, 64'd0);

        // Register change mid-unit only applies after the unit drains.
        set_ctrl(2, 0);
        idle(1'b1);
        step(1'b1, 1, 0, 32'h0000_00AA, 1'b1);
        set_ctrl(4, 0);
        step(1'b1, 1, 1, 32'h0000_BB00, 1'b1);
        #1 check_eq("cfg_hold_data", {27'd0, push_data}, {27'd0, 3'd2, 2'd0, 32'h0000_BBAA});
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 4, 0, 32'h1234_5678, 1'b1);
        #1 check_eq("cfg_new_data", {27'd0, push_data}, {27'd0, 3'd4, 2'd0, 32'h1234_5678});
        idle(1'b1);

        // Reset with three stale bytes held.
        idle(1'b1);
        step(1'b1, 3, 0, 32'h00CC_BBAA, 1'b0);
        #1 check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
        set_ctrl(2, 0);
        apply_reset();
        idle(1'b1);
        step(1'b1, 2, 2, 32'h6655_0000, 1'b1);
        #1 check_eq("post_rst_data", {27'd0, push_data}, {27'd0, 3'd2, 2'd0, 32'h0000_6655});
        idle(1'b1);

        // Random traffic against the queue model.
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, 6);
                set_ctrl(cs[k], co[k]);
            end
            if (it == 400) apply_reset();
            psz = $urandom_range(1, 4);
            step($urandom_range(0, 3) != 0, psz, $urandom_range(0, 4 - psz),
                 $urandom, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
